// File: rtl/pbkdf2_arbiter.sv
// pbkdf2_arbiter: shares one pbkdf2 core among NREQ requesters.
// Round-robin grant, key latch, core enable/done sequencing, and
// per-owner valid/ready result return.
// Optional build macro: PBKDF2_ARB_TIMEOUT_EN adds a RUN watchdog that
// ends a stuck job after TIMEOUT_CYCLES with rsp_err=1 and a zero result.
module pbkdf2_arbiter #(
    parameter int unsigned NREQ           = 4,
    parameter int unsigned KEY_BYTES      = 128,
    parameter int unsigned RESULT_W       = 512,
    parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NREQ-1:0]             req,
    input  logic [NREQ*KEY_BYTES*8-1:0] req_key,
    output logic [NREQ-1:0]             ack,
    output logic [NREQ-1:0]             rsp_valid,
    input  logic [NREQ-1:0]             rsp_ready,
    output logic [RESULT_W-1:0]         rsp_result,
    output logic                        rsp_err,
    output logic                        busy,
    output logic [$clog2(NREQ)-1:0]     owner,
    output logic                        core_en,
    output logic [KEY_BYTES*8-1:0]      core_key,
    input  logic                        core_done,
    input  logic [RESULT_W-1:0]         core_result
);

    localparam int unsigned KEY_W = KEY_BYTES * 8;
    localparam int unsigned OW    = $clog2(NREQ);

    // Elaboration-time parameter sanity checks
    if (NREQ < 2) begin : g_chk_nreq
        $error("pbkdf2_arbiter: NREQ must be at least 2");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_chk_timeout
        $error("pbkdf2_arbiter: TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [OW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [OW-1:0]       owner_d;
    logic [KEY_W-1:0]    key_d;
    logic [RESULT_W-1:0] res_d;
    logic [NREQ-1:0]     ack_d;
    logic [NREQ-1:0]     rsp_valid_d;
    logic                busy_d;
    logic                core_en_d;

    logic                found;
    logic [OW-1:0]       grant_idx;
    int unsigned         idx;

    // Per-requester view of the flat key bus
    logic [KEY_W-1:0] key_slice [NREQ];
    for (genvar g = 0; g < NREQ; g++) begin : g_key_slice
        assign key_slice[g] = req_key[g*KEY_W +: KEY_W];
    end

`ifdef PBKDF2_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_d;
`endif

    // Round-robin search: first pending requester at or after rr_ptr
    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        idx       = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = (32'(rr_ptr_q) + k) % NREQ;
            if (!found && req[OW'(idx)]) begin
                found     = 1'b1;
                grant_idx = OW'(idx);
            end
        end
    end

    // Next-state and next-value logic for all registered outputs
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner;
        key_d    = core_key;
        res_d    = rsp_result;
        ack_d    = '0;
`ifdef PBKDF2_ARB_TIMEOUT_EN
        cnt_d    = cnt_q;
        err_d    = rsp_err;
`endif
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    key_d            = key_slice[grant_idx];
                    owner_d          = grant_idx;
                    ack_d[grant_idx] = 1'b1;
                    state_d          = LOAD;
                end
            end
            LOAD: begin
`ifdef PBKDF2_ARB_TIMEOUT_EN
                cnt_d   = '0;
`endif
                state_d = RUN;
            end
            RUN: begin
`ifdef PBKDF2_ARB_TIMEOUT_EN
                cnt_d = cnt_q + CNT_W'(1);
`endif
                if (core_done) begin
                    res_d   = core_result;
`ifdef PBKDF2_ARB_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                    state_d = RESP;
                end
`ifdef PBKDF2_ARB_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    res_d   = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end
`endif
            end
            RESP: begin
                if (rsp_ready[owner]) begin
`ifdef PBKDF2_ARB_TIMEOUT_EN
                    err_d    = 1'b0;
`endif
                    rr_ptr_d = (owner == OW'(NREQ - 1)) ? '0 : owner + OW'(1);
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d      = (state_d != IDLE);
        core_en_d   = (state_d == RUN);
        rsp_valid_d = (state_d == RESP) ? (NREQ'(1) << owner_d) : '0;
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr_q   <= '0;
            owner      <= '0;
            core_key   <= '0;
            rsp_result <= '0;
            ack        <= '0;
            rsp_valid  <= '0;
            busy       <= 1'b0;
            core_en    <= 1'b0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            owner      <= owner_d;
            core_key   <= key_d;
            rsp_result <= res_d;
            ack        <= ack_d;
            rsp_valid  <= rsp_valid_d;
            busy       <= busy_d;
            core_en    <= core_en_d;
        end
    end

`ifdef PBKDF2_ARB_TIMEOUT_EN
    // Watchdog counter and error flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            rsp_err <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            rsp_err <= err_d;
        end
    end
`else
    assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_pbkdf2_arbiter.sv
// Testbench for pbkdf2_arbiter: mock core, scoreboard of expected responses
// (pushed when a request is driven, popped on each response handshake).
module tb_pbkdf2_arbiter;

    localparam int unsigned NREQ = 4;
    localparam int unsigned KB   = 128;
    localparam int unsigned KW   = KB * 8;
    localparam int unsigned RW   = 512;
    localparam int unsigned TO   = 16;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NREQ-1:0]      req;
    logic [NREQ*KW-1:0]   req_key;
    logic [NREQ-1:0]      ack;
    logic [NREQ-1:0]      rsp_valid;
    logic [NREQ-1:0]      rsp_ready;
    logic [RW-1:0]        rsp_result;
    logic                 rsp_err;
    logic                 busy;
    logic [1:0]           owner;
    logic                 core_en;
    logic [KW-1:0]        core_key;
    logic                 core_done;
    logic [RW-1:0]        core_result;

    logic [KW-1:0]        keys [NREQ];
    logic [NREQ-1:0]      ready_mask;
    logic                 hang;
    int                   mcnt;
    int                   remaining [NREQ];

    typedef struct {
        int            idx;
        logic [RW-1:0] res;
        logic          err;
    } exp_t;

    exp_t sb[$];
    int   grants[$];
    int   checks;
    int   failures;
    int   ack_count;

    pbkdf2_arbiter #(
        .NREQ(NREQ), .KEY_BYTES(KB), .RESULT_W(RW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .req_key(req_key),
        .ack(ack), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_err(rsp_err), .busy(busy),
        .owner(owner), .core_en(core_en), .core_key(core_key),
        .core_done(core_done), .core_result(core_result)
    );

    always #5 clk = ~clk;

    for (genvar g = 0; g < NREQ; g++) begin : g_key
        assign req_key[g*KW +: KW] = keys[g];
    end
    assign rsp_ready = ready_mask;

    // Mock core: done (level) 40 cycles after core_en rises; result = key bytes 0..7
    always @(posedge clk) begin
        if (!core_en) mcnt <= 0;
        else if (mcnt < 40) mcnt <= mcnt + 1;
    end
    assign core_done   = core_en && (mcnt == 40) && !hang;
    assign core_result = {448'b0, core_key[KW-1 -: 64]};

    task automatic check_eq(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [RW-1:0] model(input int i);
        return {448'b0, keys[i][KW-1 -: 64]};
    endfunction

    task automatic push_job(input int i, input logic [RW-1:0] r, input logic e);
        exp_t t;
        t.idx = i; t.res = r; t.err = e;
        sb.push_back(t);
        remaining[i]++;
    endtask

    task automatic wait_core_en(input string tag);
        int n = 0;
        while (!core_en && n < 100) begin @(negedge clk); n++; end
        check_eq(tag, 512'(core_en), 512'(1));
    endtask

    task automatic cycles_to_rsp(output int n);
        n = 0;
        do begin @(negedge clk); n++; end while (rsp_valid == '0 && n < 300);
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin @(negedge clk); n++; end
        check_eq(tag, 512'(sb.size()), 512'(0));
    endtask

    // Monitor: protocol checks, grant log, scoreboard compare, request driver
    initial begin
        logic [NREQ-1:0] prev_ack;
        exp_t            e;
        int              ridx;
        req      = '0;
        prev_ack = '0;
        forever begin
            @(negedge clk);
            if (rsp_valid != '0)
                check_eq("rsp_onehot", 512'($countones(rsp_valid)), 512'(1));
            if (ack != '0) begin
                check_eq("ack_onehot", 512'($countones(ack)), 512'(1));
                check_eq("ack_pulse", 512'(ack & prev_ack), 512'(0));
                for (int i = 0; i < NREQ; i++) begin
                    if (ack[i]) begin
                        grants.push_back(i);
                        ack_count++;
                        check_eq("core_key", 512'(core_key[KW-1 -: 64]), 512'(keys[i][KW-1 -: 64]));
                        check_eq("owner_at_ack", 512'(owner), 512'(i));
                        if (remaining[i] > 0) remaining[i]--;
                    end
                end
            end
            prev_ack = ack;
            if ((rsp_valid & rsp_ready) != '0) begin
                ridx = 0;
                for (int i = 0; i < NREQ; i++) if (rsp_valid[i]) ridx = i;
                check_eq("sb_nonempty", 512'(sb.size() != 0), 512'(1));
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check_eq("rsp_owner", 512'(ridx), 512'(e.idx));
                    check_eq("rsp_result", rsp_result, e.res);
                    check_eq("rsp_err", 512'(rsp_err), 512'(e.err));
                end
            end
            for (int i = 0; i < NREQ; i++) req[i] = (remaining[i] != 0);
        end
    end

    initial begin
        int n;
        int order [5];
        logic [NREQ-1:0] v_snap;
        logic [RW-1:0]   r_snap;
        int              acks0;

        checks = 0; failures = 0; ack_count = 0;
        hang = 1'b0;
        ready_mask = '1;
        for (int i = 0; i < NREQ; i++) remaining[i] = 0;
        keys[0] = {64'h7465614368657200, {30{$urandom}}};
        for (int i = 1; i < NREQ; i++) keys[i] = {$urandom, $urandom, {30{$urandom}}};
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_ack", 512'(ack), 512'(0));
        check_eq("rst_rsp_valid", 512'(rsp_valid), 512'(0));
        check_eq("rst_busy", 512'(busy), 512'(0));
        check_eq("rst_core_en", 512'(core_en), 512'(0));
        check_eq("rst_owner", 512'(owner), 512'(0));
        check_eq("rst_core_key", 512'(core_key[KW-1 -: 64]), 512'(0));
        check_eq("rst_rsp_result", rsp_result, 512'(0));
        check_eq("rst_rsp_err", 512'(rsp_err), 512'(0));
        reset = 1'b0;

        // Single job
        ack_count = 0;
        push_job(0, 512'h7465614368657200, 1'b0);
        wait_core_en("single_core_en");
        cycles_to_rsp(n);
        check_eq("single_latency", 512'(n), 512'(41));
        wait_done("single_done", 50);
        check_eq("single_ack_count", 512'(ack_count), 512'(1));

        // Contention from reset release
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1;
        grants.delete();
        sb.delete();
        for (int i = 0; i < NREQ; i++) push_job(i, model(i), 1'b0);
        push_job(0, model(0), 1'b0);
        @(negedge clk);
        @(posedge clk); #1 reset = 1'b0;
        wait_done("contention_done", 1000);
        order = '{0, 1, 2, 3, 0};
        check_eq("contention_grants", 512'(grants.size()), 512'(5));
        for (int i = 0; i < 5 && i < grants.size(); i++)
            check_eq("contention_order", 512'(grants[i]), 512'(order[i]));

        // Backpressure on requester 2; requester 1 waits and its ready is ignored
        grants.delete();
        ready_mask = 4'b1011;
        push_job(2, model(2), 1'b0);
        n = 0;
        while (!rsp_valid[2] && n < 300) begin @(negedge clk); n++; end
        check_eq("bp_rsp_valid", 512'(rsp_valid), 512'(4'b0100));
        push_job(1, model(1), 1'b0);
        v_snap = rsp_valid;
        r_snap = rsp_result;
        acks0  = ack_count;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check_eq("bp_valid_stable", 512'(rsp_valid), 512'(v_snap));
            check_eq("bp_result_stable", rsp_result, r_snap);
            check_eq("bp_core_en", 512'(core_en), 512'(0));
            check_eq("bp_busy", 512'(busy), 512'(1));
        end
        check_eq("bp_no_ack", 512'(ack_count), 512'(acks0));
        @(posedge clk); #1 ready_mask = '1;
        wait_done("bp_done", 300);
        check_eq("bp_grants", 512'(grants.size()), 512'(2));
        if (grants.size() == 2) begin
            check_eq("bp_order0", 512'(grants[0]), 512'(2));
            check_eq("bp_order1", 512'(grants[1]), 512'(1));
        end

        // Reset mid-RUN: rr_ptr returns to 0 so requester 0 beats 3
        push_job(2, model(2), 1'b0);
        wait_core_en("rst_job_core_en");
        repeat (10) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check_eq("async_core_en", 512'(core_en), 512'(0));
        check_eq("async_busy", 512'(busy), 512'(0));
        check_eq("async_ack", 512'(ack), 512'(0));
        check_eq("async_rsp_valid", 512'(rsp_valid), 512'(0));
        sb.delete();
        grants.delete();
        for (int i = 0; i < NREQ; i++) remaining[i] = 0;
        push_job(0, model(0), 1'b0);
        push_job(3, model(3), 1'b0);
        @(negedge clk);
        @(posedge clk); #1 reset = 1'b0;
        wait_done("rst_done", 300);
        check_eq("rst_grants", 512'(grants.size()), 512'(2));
        if (grants.size() == 2) begin
            check_eq("rst_first_grant", 512'(grants[0]), 512'(0));
            check_eq("rst_second_grant", 512'(grants[1]), 512'(3));
        end

        // Core never finishes
        hang = 1'b1;
`ifdef PBKDF2_ARB_TIMEOUT_EN
        push_job(1, 512'(0), 1'b1);
        wait_core_en("to_core_en");
        cycles_to_rsp(n);
        check_eq("to_latency", 512'(n), 512'(TO));
        wait_done("to_done", 50);
`else
        remaining[1] = 1;
        wait_core_en("hang_core_en");
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            check_eq("hang_core_en_hold", 512'(core_en), 512'(1));
            check_eq("hang_no_rsp", 512'(rsp_valid), 512'(0));
        end
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
`endif
        hang = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
